// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the fetch-side pipeline control (pipe_if_id).
//   - NOP_INST          : instruction injected into IF/ID on a bubble
//                         (sll $0,$0,0).
//   - DEFAULT_RESET_PC  : PC loaded on reset unless overridden.
//   - state_e           : IF/ID control FSM states, 2-bit encoding.
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

endpackage : pipe_pkg

// File: rtl/pipe_if_id_dffe32.sv
// ---------------------------------------------------------------------------
// dffe32
//   32-bit register with asynchronous active-high reset to a supplied value
//   and a synchronous load enable.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   asynchronous active-high reset
//     rst_val in   value taken while rst is high
//     en      in   load enable
//     d       in   data to load
//     q       out  registered value
// ---------------------------------------------------------------------------
module dffe32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rst_val,
   input  logic        en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= rst_val;
      end else if (en) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule : dffe32

// File: rtl/pipe_if_id.sv
// ---------------------------------------------------------------------------
// pipe_if_id
//   Fetch-side control and IF/ID pipeline register of the 5-stage MIPS
//   pipeline. Owns the architectural PC, captures the fetched instruction
//   with its PC and pc+8 for decode, and applies stall/flush requests from
//   the hazard unit. Every output is registered.
//
//   Optional build macro: PIPE_IF_ID_PERF_EN enables the saturating
//   stall_cycles / flush_count performance counters; without it both ports
//   are tied to zero.
//
//   Ports:
//     clk          in   pipeline clock, rising edge
//     rst          in   asynchronous active-high reset
//     stall        in   hold PC and IF/ID contents
//     flush        in   squash the IF/ID capture (wins over stall)
//     npc[31:0]    in   next PC from fetch
//     inst_in      in   instruction at the current pc
//     pc8_in       in   pc+8 from fetch
//     pc           out  current PC to fetch
//     id_inst      out  IF/ID instruction
//     id_pc        out  IF/ID PC of that instruction
//     id_pc8       out  IF/ID pc+8 (jal link address)
//     id_valid     out  IF/ID holds a real instruction
//     stall_cycles out  perf: stalled-cycle count
//     flush_count  out  perf: flush-event count
// ---------------------------------------------------------------------------
module pipe_if_id
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = pipe_pkg::DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] npc,
   input  logic [31:0] inst_in,
   input  logic [31:0] pc8_in,
   output logic [31:0] pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8,
   output logic        id_valid,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   state_e      state_q, state_d;
   logic        id_valid_q, id_valid_d;
   logic        pc_en;
   logic        id_en;
   logic        bubble;
   logic        stall_evt;
   logic        flush_evt;
   logic [31:0] id_inst_d, id_pc_d, id_pc8_d;

   // ---- control FSM ------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_BOOT;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_valid_q <= id_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_en     = 1'b0;
      id_en     = 1'b0;
      bubble    = 1'b0;
      stall_evt = 1'b0;
      flush_evt = 1'b0;
      case (state_q)
         // One idle edge so instruction memory settles on RESET_PC;
         // stall/flush are ignored here.
         S_BOOT: state_d = S_RUN;
         S_RUN, S_HOLD: begin
            if (flush) begin
               // Redirect still loads npc; IF/ID gets a bubble.
               pc_en     = 1'b1;
               id_en     = 1'b1;
               bubble    = 1'b1;
               flush_evt = 1'b1;
               state_d   = S_RUN;
            end else if (stall) begin
               stall_evt = 1'b1;
               state_d   = S_HOLD;
            end else begin
               pc_en   = 1'b1;
               id_en   = 1'b1;
               state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase

      id_inst_d  = bubble ? NOP_INST : inst_in;
      id_pc_d    = bubble ? 32'h0 : pc;
      id_pc8_d   = bubble ? 32'h0 : pc8_in;
      id_valid_d = id_en ? ~bubble : id_valid_q;
   end

   // ---- datapath registers ---------------------------------------------
   dffe32 u_pc (
      .clk(clk), .rst(rst), .rst_val(RESET_PC),
      .en(pc_en), .d(npc), .q(pc)
   );

   dffe32 u_id_inst (
      .clk(clk), .rst(rst), .rst_val(NOP_INST),
      .en(id_en), .d(id_inst_d), .q(id_inst)
   );

   dffe32 u_id_pc (
      .clk(clk), .rst(rst), .rst_val(32'h0),
      .en(id_en), .d(id_pc_d), .q(id_pc)
   );

   dffe32 u_id_pc8 (
      .clk(clk), .rst(rst), .rst_val(32'h0),
      .en(id_en), .d(id_pc8_d), .q(id_pc8)
   );

   assign id_valid = id_valid_q;

   // ---- performance counters -------------------------------------------
`ifdef PIPE_IF_ID_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      // Both counters saturate rather than wrap.
      if (stall_evt && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (flush_evt && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'h0;
         flush_count_q  <= 32'h0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   logic unused_perf;
   assign unused_perf  = stall_evt ^ flush_evt;
   assign stall_cycles = 32'h0;
   assign flush_count  = 32'h0;
`endif

endmodule : pipe_if_id

// File: tb/tb_pipe_if_id.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_id
//   Directed testbench for pipe_if_id. Inputs change on the falling edge,
//   outputs are checked on the falling edge after each rising edge.
//   Expected counter values follow PIPE_IF_ID_PERF_EN (zero when undefined).
// ---------------------------------------------------------------------------
module tb_pipe_if_id;
   import pipe_pkg::*;

`ifdef PIPE_IF_ID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // ---- clock / reset ----------------------------------------------------
   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] npc;
   logic [31:0] inst_in;
   logic [31:0] pc8_in;
   logic [31:0] pc;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc8;
   logic        id_valid;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int n_vec;
   int n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_if_id dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .npc(npc), .inst_in(inst_in), .pc8_in(pc8_in),
      .pc(pc), .id_inst(id_inst), .id_pc(id_pc), .id_pc8(id_pc8),
      .id_valid(id_valid), .stall_cycles(stall_cycles),
      .flush_count(flush_count)
   );

   // ---- checker ----------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] perf(input logic [31:0] v);
      return PERF ? v : 32'h0;
   endfunction

   // ---- driver -------------------------------------------------------------
   // Apply inputs, take one rising edge, return on the following falling edge.
   task automatic step(input logic s, input logic f, input logic [31:0] n,
                       input logic [31:0] inst, input logic [31:0] p8);
      stall   = s;
      flush   = f;
      npc     = n;
      inst_in = inst;
      pc8_in  = p8;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_id(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input logic [31:0] e_idpc,
                           input logic [31:0] e_pc8, input logic e_valid);
      check({tag, ".pc"},       pc,              e_pc);
      check({tag, ".id_inst"},  id_inst,         e_inst);
      check({tag, ".id_pc"},    id_pc,           e_idpc);
      check({tag, ".id_pc8"},   id_pc8,          e_pc8);
      check({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, e_valid});
   endtask

   // ---- stimulus -----------------------------------------------------------
   initial begin
      n_vec   = 0;
      n_bad   = 0;
      rst     = 1'b1;
      stall   = 1'b0;
      flush   = 1'b0;
      npc     = 32'h0;
      inst_in = 32'h0;
      pc8_in  = 32'h0;
      repeat (2) @(negedge clk);

      // reset state
      check_id("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("reset.state", 32'(dut.state_q), 32'(S_BOOT));
      check("reset.stall_cycles", stall_cycles, 32'h0);
      check("reset.flush_count", flush_count, 32'h0);
      rst = 1'b0;

      // BOOT edge: stall/flush asserted but ignored, nothing counted
      step(1'b1, 1'b1, 32'h4, 32'h2001_0005, 32'h8);
      check_id("boot", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("boot.state", 32'(dut.state_q), 32'(S_RUN));
      check("boot.stall_cycles", stall_cycles, 32'h0);
      check("boot.flush_count", flush_count, 32'h0);

      // first capture
      step(1'b0, 1'b0, 32'h4, 32'h2001_0005, 32'h8);
      check_id("first", 32'h4, 32'h2001_0005, 32'h0, 32'h8, 1'b1);

      // run up to pc=0x10
      step(1'b0, 1'b0, 32'h8,  32'hA000_0004, 32'hC);
      step(1'b0, 1'b0, 32'hC,  32'hA000_0008, 32'h10);
      step(1'b0, 1'b0, 32'h10, 32'hA000_000C, 32'h14);
      check_id("run", 32'h10, 32'hA000_000C, 32'hC, 32'h14, 1'b1);

      // 3-cycle stall at pc=0x10: everything holds
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h14, 32'hA000_0010, 32'h18);
         check_id("stall", 32'h10, 32'hA000_000C, 32'hC, 32'h14, 1'b1);
         check("stall.state", 32'(dut.state_q), 32'(S_HOLD));
      end
      check("stall.stall_cycles", stall_cycles, perf(32'd3));

      // release: capture resumes with the instruction at 0x10
      step(1'b0, 1'b0, 32'h14, 32'hA000_0010, 32'h18);
      check_id("release", 32'h14, 32'hA000_0010, 32'h10, 32'h18, 1'b1);
      check("release.state", 32'(dut.state_q), 32'(S_RUN));

      // flush redirect to 0x40
      step(1'b0, 1'b1, 32'h40, 32'hA000_0014, 32'h1C);
      check_id("flush", 32'h40, 32'h0, 32'h0, 32'h0, 1'b0);
      check("flush.flush_count", flush_count, perf(32'd1));
      step(1'b0, 1'b0, 32'h44, 32'hA000_0040, 32'h48);
      check_id("post_flush", 32'h44, 32'hA000_0040, 32'h40, 32'h48, 1'b1);

      // stall and flush together: flush wins
      step(1'b1, 1'b1, 32'h80, 32'hA000_0044, 32'h4C);
      check_id("stall_flush", 32'h80, 32'h0, 32'h0, 32'h0, 1'b0);
      check("stall_flush.state", 32'(dut.state_q), 32'(S_RUN));
      check("stall_flush.stall_cycles", stall_cycles, perf(32'd3));
      check("stall_flush.flush_count", flush_count, perf(32'd2));

      // get to HOLD at pc=0x20, then reset asynchronously between edges
      step(1'b0, 1'b1, 32'h20, 32'hA000_0080, 32'h88);
      step(1'b1, 1'b0, 32'h24, 32'hA000_0020, 32'h28);
      check("hold.pc", pc, 32'h20);
      check("hold.state", 32'(dut.state_q), 32'(S_HOLD));
      #2 rst = 1'b1;
      #1;
      check_id("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("async_rst.state", 32'(dut.state_q), 32'(S_BOOT));
      check("async_rst.stall_cycles", stall_cycles, 32'h0);
      check("async_rst.flush_count", flush_count, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 32'h4, 32'h2001_0005, 32'h8);
      check_id("reboot", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("reboot.state", 32'(dut.state_q), 32'(S_RUN));
      step(1'b0, 1'b0, 32'h4, 32'h2001_0005, 32'h8);
      check_id("rerun", 32'h4, 32'h2001_0005, 32'h0, 32'h8, 1'b1);

      // pc wrap at the top of the address space
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA000_0004, 32'hC);
      check("wrap.pc_top", pc, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h4);
      check_id("wrap", 32'h0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_pipe_if_id

// File: doc/pipe_if_id.md
Name: pipe_if_id

Overview:
- Fetch-side control and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the architectural PC register that drives the fetch stage, and loads it each cycle with the fetch stage's npc.
- Captures the fetched instruction, its PC and pc8 into the IF/ID latch consumed by decode.
- Applies load-use stall and branch/jump flush requests coming back from ID/hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction injected on flush/bubble (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
flush  input  1  hazard unit: squash instruction currently in IF/ID path
npc  input  32  next PC from fetch stage
inst_in  input  32  instruction read from instruction memory for current pc
pc8_in  input  32  pc+8 from fetch stage
pc  output  32  current PC to fetch stage
id_inst  output  32  IF/ID instruction
id_pc  output  32  IF/ID PC of that instruction
id_pc8  output  32  IF/ID pc+8 (link address for jal)
id_valid  output  1  IF/ID holds a real instruction
stall_cycles  output  32  perf: stalled-cycle count (see Optional Feature)
flush_count  output  32  perf: flush-event count (see Optional Feature)

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-stall): pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_pc8=0, id_valid=0, state=BOOT, counters=0.
- FSM states: BOOT, RUN, HOLD. 2-bit encoding.
- BOOT (first edge after rst deasserts):
  - pc unchanged, IF/ID unchanged (id_valid stays 0).
  - Next state RUN unconditionally; stall/flush ignored.
  - Gives instruction memory one cycle to settle on RESET_PC.
- RUN, per edge:
  - flush=1 (priority over stall): pc<=npc (redirect must take effect); id_inst<=NOP_INST, id_pc<=0, id_pc8<=0, id_valid<=0; next RUN.
  - stall=1, flush=0: pc and IF/ID hold; next HOLD.
  - Neither: pc<=npc; id_inst<=inst_in, id_pc<=pc, id_pc8<=pc8_in, id_valid<=1; next RUN.
- HOLD: identical edge rules to RUN.
  - stall=1 stays HOLD.
  - stall=0 returns RUN with normal capture on that edge.
  - flush exits to RUN with a bubble.
- Latency: the instruction at pc appears on id_* one edge after pc is presented.
- pc wraps naturally modulo 2^32; no alignment check (fetch uses pc[6:2]).
- All outputs are registered; no combinational path from stall/flush/npc to any output.

Optional Feature:
Macro PIPE_IF_ID_PERF_EN.
- Defined:
  - stall_cycles increments on every edge in RUN/HOLD with stall=1 and flush=0.
  - flush_count increments on every edge in RUN/HOLD with flush=1.
  - Both saturate at 32'hFFFF_FFFF, are cleared by rst, and do not count in BOOT.
- Not defined: counters not built; stall_cycles and flush_count tied to 0. Port list is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INST constant
  - FSM state encodings S_BOOT=2'd0, S_RUN=2'd1, S_HOLD=2'd2
  - default RESET_PC
- Natural sub-module: dffe32, a 32-bit register with async active-high reset value input and load enable, instantiated for pc, id_inst, id_pc and id_pc8.
- FSM and counters stay in the top.

Test Plan:
- Reset release, npc=pc+4 loop, inst_in=32'h2001_0005:
  - BOOT cycle: pc=0, id_valid=0.
  - Next edge: pc=4, id_inst=32'h2001_0005, id_pc=0, id_pc8=8, id_valid=1.
- In RUN at pc=32'h10, stall=1 for 3 cycles:
  - pc holds 32'h10 and id_* hold for 3 edges.
  - On release, capture resumes at pc 32'h10.
  - stall_cycles=3 when PIPE_IF_ID_PERF_EN is defined.
- flush=1 with npc=32'h40:
  - Next edge: pc=32'h40, id_inst=0, id_valid=0, flush_count=1.
  - Following edge: id_pc=32'h40.
- stall=1 and flush=1 same cycle, npc=32'h80: flush wins, giving pc=32'h80, bubble in IF/ID, state RUN, stall_cycles unchanged.
- Assert rst mid-HOLD at pc=32'h20, asynchronously between edges:
  - Immediately: pc=RESET_PC, id_valid=0, counters=0.
  - After release: BOOT then RUN.
- pc=32'hFFFF_FFFC, npc=32'h0000_0000: pc wraps to 0; id_pc=32'hFFFF_FFFC captured, id_valid=1.
